multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Sequential successor to the single-cycle combinational decoder: a parametrised multi-cycle MIPS control FSM. It sequences fetch, decode, execute, memory and writeback over several clocks. It holds a valid/ready handshake with memory, with an optional wait timeout, and drives the datapath mux, memory and ALU controls plus PC/IR write enables. Supported instructions: add, sub, and, or, slt, lw, sw, beq, addi, j.

Parameters:
OP_W, 6, opcode field width
FUNC_W, 6, function field width
ALU_W, 4, aluctrl width
MEM_TIMEOUT, 16, maximum consecutive wait cycles on mem_ready before FAULT; 0 disables the timeout

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
op  input  OP_W  opcode from IR
func  input  FUNC_W  R-type function field from IR
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current request this cycle
muxctrl  output  7  [0] reg_dst, [1] reg_write, [2] alu_src_a, [4:3] alu_src_b (00 B, 01 const 4, 10 sext imm, 11 imm<<2), [5] mem_to_reg, [6] iord
memctrl  output  3  [2] data read, [1] data write, [0] instruction fetch; nonzero means request valid
aluctrl  output  ALU_W  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target
pc_write  output  1  PC load enable
ir_write  output  1  IR load enable
instr_done  output  1  one-cycle pulse on instruction retirement
illegal  output  1  one-cycle pulse on an undecodable op/func
fault  output  1  sticky memory-timeout flag
state  output  4  current state encoding, for debug

Behaviour:
- Clock, reset and output style
  - Single clk. reset sampled only at the rising edge; reset==0 forces state=FETCH, timeout counter=0, fault=0.
  - While reset==0, every output is 0, including memctrl, so no request is issued.
  - Outputs decode combinationally from the registered state (Moore), except the ready/zero-qualified strobes noted below.
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, FAULT 12.
- FETCH
  - memctrl=001, iord=0, alu_src_a=0, alu_src_b=01, aluctrl=add.
  - When mem_ready=1 in the same cycle: ir_write=1, pc_write=1, pc_src=00, then go to DECODE. Otherwise hold with no strobes.
- DECODE
  - alu_src_a=0, alu_src_b=11, aluctrl=add (branch target into ALUOut).
  - Dispatch: op 000000 with func 100000/100010/100100/100101/101010 -> R_EXEC; 100011 or 101011 -> MEM_ADDR; 000100 -> BRANCH; 001000 -> ADDI_EXEC; 000010 -> JUMP.
  - Any other op, or R-type with another func: illegal=1 for one cycle, then go to FETCH. No instr_done.
- R_EXEC: alu_src_a=1, alu_src_b=00, aluctrl from func (add/sub/and/or/slt), then R_WB.
- R_WB: reg_dst=1, reg_write=1, mem_to_reg=0, instr_done=1, then FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, aluctrl=add, then MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: memctrl=100, iord=1; hold until mem_ready, then MEM_WB.
- MEM_WB: reg_dst=0, reg_write=1, mem_to_reg=1, instr_done=1, then FETCH.
- MEM_WRITE: memctrl=010, iord=1; on mem_ready: instr_done=1, then FETCH.
- BRANCH
  - alu_src_a=1, alu_src_b=00, aluctrl=sub, pc_src=01.
  - pc_write=zero (combinational). instr_done=1, then FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1, then FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, aluctrl=add, then ADDI_WB.
- ADDI_WB: reg_dst=0, reg_write=1, mem_to_reg=0, instr_done=1, then FETCH.
- Latency from FETCH entry with zero-wait memory: R/addi/sw 4 cycles, lw 5, beq/j 3.
- Memory timeout
  - Counter increments each cycle in FETCH, MEM_READ or MEM_WRITE with mem_ready=0. It clears on mem_ready=1 or on leaving the state.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0 (MEM_TIMEOUT>0), go to FAULT.
  - FAULT: fault=1, all other outputs 0, held until reset.
  - mem_ready=1 on the deadline cycle wins: complete normally, no fault.
- Unused inputs: mem_ready outside a memory state is ignored. zero is ignored outside BRANCH.
- Reset asserted mid-instruction aborts it with no strobes issued that cycle.

Decomposition:
- Package controller_pkg: state enum, opcode/func constants, aluctrl codes, alu_src_b and pc_src encodings, muxctrl bit indices.
- Natural sub-module: alu_decoder (func -> aluctrl plus legal flag, combinational), shared with DECODE legality checking.

Test Plan:
- add (op 000000, func 100000), mem_ready always 1 -> states 0,1,6,7; aluctrl 0010 in R_EXEC; reg_write=1, reg_dst=1 and instr_done in cycle 4.
- lw (op 100011), mem_ready low 3 cycles in MEM_READ -> memctrl=100 held 4 cycles; MEM_WB asserts mem_to_reg=1, reg_write=1; retire after 8 cycles total.
- beq with zero=1, then with zero=0 -> pc_write=1, pc_src=01 in the first case; pc_write=0 in the second; both retire in 3 cycles.
- op 111111 -> illegal pulse in DECODE, next state FETCH, instr_done never asserted.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT after 4 wait cycles; fault=1, memctrl=000 until reset.
- reset driven 0 during MEM_WRITE -> next edge state=0 with all outputs 0; after release, FETCH issues memctrl=001.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state enum, opcode/func
// constants, ALU control codes and datapath-select field layouts.
package controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_FAULT     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam int MUX_REG_DST    = 0;
  localparam int MUX_REG_WRITE  = 1;
  localparam int MUX_ALU_SRC_A  = 2;
  localparam int MUX_ALU_SRC_B  = 3;
  localparam int MUX_MEM_TO_REG = 5;
  localparam int MUX_IORD       = 6;

  localparam int MEMC_IFETCH = 0;
  localparam int MEMC_WR     = 1;
  localparam int MEMC_RD     = 2;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// R-type function field to ALU control; legal also gates R-type dispatch in DECODE.
module alu_decoder
  import controller_pkg::*;
#(
  parameter int FUNC_W = 6,
  parameter int ALU_W  = 4
) (
  input  logic [FUNC_W-1:0] func,
  output logic [ALU_W-1:0]  aluctrl,
  output logic              legal
);

  always_comb begin
    aluctrl = '0;
    legal   = 1'b1;
    case (func)
      FUNC_W'(FN_ADD): aluctrl = ALU_W'(ALU_ADD);
      FUNC_W'(FN_SUB): aluctrl = ALU_W'(ALU_SUB);
      FUNC_W'(FN_AND): aluctrl = ALU_W'(ALU_AND);
      FUNC_W'(FN_OR):  aluctrl = ALU_W'(ALU_OR);
      FUNC_W'(FN_SLT): aluctrl = ALU_W'(ALU_SLT);
      default:         legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/mem/writeback sequencing,
// memory handshake with optional wait timeout into a sticky FAULT state.
module multicycle_controller
  import controller_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int FUNC_W      = 6,
  parameter int ALU_W       = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   op,
  input  logic [FUNC_W-1:0] func,
  input  logic              zero,
  input  logic              mem_ready,
  output logic [6:0]        muxctrl,
  output logic [2:0]        memctrl,
  output logic [ALU_W-1:0]  aluctrl,
  output logic [1:0]        pc_src,
  output logic              pc_write,
  output logic              ir_write,
  output logic              instr_done,
  output logic              illegal,
  output logic              fault,
  output logic [3:0]        state
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ALU_W-1:0]   func_alu;
  logic               func_legal;
  logic               mem_wait, timeout_hit;

  logic [6:0]         mux_c;
  logic [2:0]         mem_c;
  logic [ALU_W-1:0]   alu_c;
  logic [1:0]         pcs_c;
  logic               pcw_c, irw_c, done_c, ill_c, flt_c;

  alu_decoder #(.FUNC_W(FUNC_W), .ALU_W(ALU_W)) u_alu_dec (
    .func    (func),
    .aluctrl (func_alu),
    .legal   (func_legal)
  );

  assign mem_wait    = (state_q inside {S_FETCH, S_MEM_READ, S_MEM_WRITE}) && !mem_ready;
  // Deadline is the MEM_TIMEOUT-th consecutive wait cycle; ready on that cycle still wins.
  assign timeout_hit = (MEM_TIMEOUT > 0) && mem_wait && (int'(cnt_q) == MEM_TIMEOUT - 1);

  always_comb begin
    cnt_d = '0;
    if (MEM_TIMEOUT > 0 && mem_wait && !timeout_hit) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    mux_c   = '0;
    mem_c   = '0;
    alu_c   = '0;
    pcs_c   = PC_ALU;
    pcw_c   = 1'b0;
    irw_c   = 1'b0;
    done_c  = 1'b0;
    ill_c   = 1'b0;
    flt_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_c[MEMC_IFETCH]        = 1'b1;
        mux_c[MUX_ALU_SRC_B +: 2] = SRCB_FOUR;
        alu_c                     = ALU_W'(ALU_ADD);
        if (mem_ready) begin
          irw_c   = 1'b1;
          pcw_c   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        mux_c[MUX_ALU_SRC_B +: 2] = SRCB_IMM_SH;
        alu_c                     = ALU_W'(ALU_ADD);
        if (op == OP_W'(OP_RTYPE) && func_legal)         state_d = S_R_EXEC;
        else if (op == OP_W'(OP_LW) || op == OP_W'(OP_SW)) state_d = S_MEM_ADDR;
        else if (op == OP_W'(OP_BEQ))                     state_d = S_BRANCH;
        else if (op == OP_W'(OP_ADDI))                    state_d = S_ADDI_EXEC;
        else if (op == OP_W'(OP_J))                       state_d = S_JUMP;
        else begin
          ill_c   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM_ADDR: begin
        mux_c[MUX_ALU_SRC_A]      = 1'b1;
        mux_c[MUX_ALU_SRC_B +: 2] = SRCB_IMM;
        alu_c                     = ALU_W'(ALU_ADD);
        state_d = (op == OP_W'(OP_LW)) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_c[MEMC_RD]  = 1'b1;
        mux_c[MUX_IORD] = 1'b1;
        if (mem_ready)        state_d = S_MEM_WB;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_MEM_WB: begin
        mux_c[MUX_REG_WRITE]  = 1'b1;
        mux_c[MUX_MEM_TO_REG] = 1'b1;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_c[MEMC_WR]  = 1'b1;
        mux_c[MUX_IORD] = 1'b1;
        if (mem_ready) begin
          done_c  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      S_R_EXEC: begin
        mux_c[MUX_ALU_SRC_A]      = 1'b1;
        mux_c[MUX_ALU_SRC_B +: 2] = SRCB_B;
        alu_c   = func_alu;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        mux_c[MUX_REG_DST]   = 1'b1;
        mux_c[MUX_REG_WRITE] = 1'b1;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        mux_c[MUX_ALU_SRC_A]      = 1'b1;
        mux_c[MUX_ALU_SRC_B +: 2] = SRCB_B;
        alu_c   = ALU_W'(ALU_SUB);
        pcs_c   = PC_ALUOUT;
        pcw_c   = zero;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcs_c   = PC_JUMP;
        pcw_c   = 1'b1;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDI_EXEC: begin
        mux_c[MUX_ALU_SRC_A]      = 1'b1;
        mux_c[MUX_ALU_SRC_B +: 2] = SRCB_IMM;
        alu_c   = ALU_W'(ALU_ADD);
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        mux_c[MUX_REG_WRITE] = 1'b1;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: flt_c = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Holding reset silences everything immediately, before the next edge lands.
  assign muxctrl    = reset ? mux_c  : '0;
  assign memctrl    = reset ? mem_c  : '0;
  assign aluctrl    = reset ? alu_c  : '0;
  assign pc_src     = reset ? pcs_c  : '0;
  assign pc_write   = reset && pcw_c;
  assign ir_write   = reset && irw_c;
  assign instr_done = reset && done_c;
  assign illegal    = reset && ill_c;
  assign fault      = reset && flt_c;
  assign state      = reset ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with MEM_TIMEOUT=4: every step compares
// the full output snapshot against a hand-computed expected vector.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, func;
  logic       zero, mem_ready;
  logic [6:0] muxctrl;
  logic [2:0] memctrl;
  logic [3:0] aluctrl;
  logic [1:0] pc_src;
  logic       pc_write, ir_write, instr_done, illegal, fault;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  multicycle_controller #(
    .OP_W(6), .FUNC_W(6), .ALU_W(4), .MEM_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .func       (func),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .muxctrl    (muxctrl),
    .memctrl    (memctrl),
    .aluctrl    (aluctrl),
    .pc_src     (pc_src),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .instr_done (instr_done),
    .illegal    (illegal),
    .fault      (fault),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Snapshot layout: {state, muxctrl, memctrl, aluctrl, pc_src, pc_write, ir_write, instr_done, illegal, fault}
  task automatic chk(input string tag, input logic [3:0] st, input logic [6:0] mux,
                     input logic [2:0] mem, input logic [3:0] alu, input logic [1:0] pcs,
                     input logic pcw, input logic irw, input logic done, input logic ill,
                     input logic flt);
    logic [24:0] obs, exp;
    obs = {state, muxctrl, memctrl, aluctrl, pc_src, pc_write, ir_write, instr_done, illegal, fault};
    exp = {st, mux, mem, alu, pcs, pcw, irw, done, ill, flt};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%07h expected=%07h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    chk("reset_quiet", 4'd0, 7'h00, 3'b000, 4'h0, 2'b00, 0, 0, 0, 0, 0);

    // add, zero-wait memory: 0,1,6,7
    reset = 1'b1; op = 6'b000000; func = 6'b100000; #1;
    chk("add_fetch", 4'd0, 7'h08, 3'b001, 4'b0010, 2'b00, 1, 1, 0, 0, 0);
    tick(); chk("add_decode", 4'd1, 7'h18, 3'b000, 4'b0010, 2'b00, 0, 0, 0, 0, 0);
    tick(); chk("add_exec",   4'd6, 7'h04, 3'b000, 4'b0010, 2'b00, 0, 0, 0, 0, 0);
    tick(); chk("add_wb",     4'd7, 7'h03, 3'b000, 4'b0000, 2'b00, 0, 0, 1, 0, 0);
    tick();

    // slt picks its own ALU code in R_EXEC
    func = 6'b101010;
    tick(); tick(); chk("slt_exec", 4'd6, 7'h04, 3'b000, 4'b0111, 2'b00, 0, 0, 0, 0, 0);
    tick(); tick();

    // lw with 3 wait cycles; ready arrives on the timeout deadline cycle and wins
    op = 6'b100011;
    tick(); tick(); chk("lw_addr", 4'd2, 7'h14, 3'b000, 4'b0010, 2'b00, 0, 0, 0, 0, 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("lw_wait%0d", i), 4'd3, 7'h40, 3'b100, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    end
    tick(); mem_ready = 1'b1; #1;
    chk("lw_ready", 4'd3, 7'h40, 3'b100, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    tick(); chk("lw_wb", 4'd4, 7'h22, 3'b000, 4'h0, 2'b00, 0, 0, 1, 0, 0);
    tick(); chk("lw_back", 4'd0, 7'h08, 3'b001, 4'b0010, 2'b00, 1, 1, 0, 0, 0);

    // beq taken then not taken
    op = 6'b000100; zero = 1'b1;
    tick(); tick(); chk("beq_taken", 4'd8, 7'h04, 3'b000, 4'b0110, 2'b01, 1, 0, 1, 0, 0);
    tick(); zero = 1'b0;
    tick(); tick(); chk("beq_not", 4'd8, 7'h04, 3'b000, 4'b0110, 2'b01, 0, 0, 1, 0, 0);
    tick();

    // jump and addi
    op = 6'b000010;
    tick(); tick(); chk("jump", 4'd9, 7'h00, 3'b000, 4'h0, 2'b10, 1, 0, 1, 0, 0);
    tick(); op = 6'b001000;
    tick(); tick(); chk("addi_exec", 4'd10, 7'h14, 3'b000, 4'b0010, 2'b00, 0, 0, 0, 0, 0);
    tick(); chk("addi_wb", 4'd11, 7'h02, 3'b000, 4'h0, 2'b00, 0, 0, 1, 0, 0);
    tick();

    // illegal opcode and illegal R-type func
    op = 6'b111111;
    tick(); chk("ill_op", 4'd1, 7'h18, 3'b000, 4'b0010, 2'b00, 0, 0, 0, 1, 0);
    tick(); chk("ill_back", 4'd0, 7'h08, 3'b001, 4'b0010, 2'b00, 1, 1, 0, 0, 0);
    op = 6'b000000; func = 6'b000111;
    tick(); chk("ill_func", 4'd1, 7'h18, 3'b000, 4'b0010, 2'b00, 0, 0, 0, 1, 0);
    tick();

    // sw aborted by reset while waiting in MEM_WRITE
    op = 6'b101011;
    tick(); tick(); mem_ready = 1'b0;
    tick(); chk("sw_wait", 4'd5, 7'h40, 3'b010, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    reset = 1'b0; mem_ready = 1'b1; #1;
    chk("sw_rst_comb", 4'd0, 7'h00, 3'b000, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    tick(); chk("sw_rst_edge", 4'd0, 7'h00, 3'b000, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    reset = 1'b1; mem_ready = 1'b0; #1;
    chk("post_rst_fetch", 4'd0, 7'h08, 3'b001, 4'b0010, 2'b00, 0, 0, 0, 0, 0);

    // fetch timeout: 4 wait cycles in FETCH, then FAULT until reset
    tick(); tick(); tick();
    chk("to_wait4", 4'd0, 7'h08, 3'b001, 4'b0010, 2'b00, 0, 0, 0, 0, 0);
    tick(); chk("to_fault", 4'd12, 7'h00, 3'b000, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    mem_ready = 1'b1;
    tick(); chk("fault_sticky", 4'd12, 7'h00, 3'b000, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    reset = 1'b0;
    tick(); chk("fault_clear", 4'd0, 7'h00, 3'b000, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    reset = 1'b1; #1;
    chk("fault_refetch", 4'd0, 7'h08, 3'b001, 4'b0010, 2'b00, 1, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
